binary_stream_accumulator: RTL and testbench

//  Parametrised bit-serial-to-binary converter for systolic term-array outputs.

---
 rtl/binary_stream_accumulator.sv | 85 ++++++++
 tb/tb_binary_stream_accumulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_stream_accumulator.sv
// Bit-serial to binary converter: NUM_LANES MSB-first lane words, lane i weighted
// by 2^i, summed into one OUT_WIDTH result behind a valid/ready output register.
module binary_stream_accumulator #(
  parameter int NUM_LANES   = 8,
  parameter int STREAM_BITS = 8,
  parameter int SIGNED      = 0,
  localparam int OUT_WIDTH  = NUM_LANES + STREAM_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_LANES-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_msb
);

  localparam int CW = (STREAM_BITS > 2) ? $clog2(STREAM_BITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STREAM_BITS - 1);

  typedef enum logic {COLLECT, LAST} phase_t;

  phase_t                                  phase;
  logic [CW-1:0]                           bit_cnt, bit_cnt_next;
  // Only STREAM_BITS-1 bits are stored; the final bit is taken live from in_bits.
  logic [NUM_LANES-1:0][STREAM_BITS-2:0]   sr, sr_next;
  logic [NUM_LANES-1:0][STREAM_BITS-1:0]   word;
  logic                                    accept, complete;
  logic [OUT_WIDTH-1:0]                    sum, ext;

  always_comb begin
    phase        = (bit_cnt == LAST_CNT) ? LAST : COLLECT;
    in_ready     = !(phase == LAST && out_valid && !out_ready);
    accept       = in_valid && in_ready && !flush;
    complete     = accept && (phase == LAST);
    bit_cnt_next = bit_cnt;
    sr_next      = sr;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      word[i] = {sr[i], in_bits[i]};
    end
    if (flush) begin
      bit_cnt_next = '0;
      sr_next      = '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        sr_next[i] = word[i][STREAM_BITS-2:0];
      end
      bit_cnt_next = (phase == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_comb begin
    sum = '0;
    ext = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (SIGNED != 0) ext = {{NUM_LANES{word[i][STREAM_BITS-1]}}, word[i]};
      else             ext = {{NUM_LANES{1'b0}}, word[i]};
      sum = sum + (ext << i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      sr        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      bit_cnt <= bit_cnt_next;
      sr      <= sr_next;
      if (complete) begin
        out_data  <= sum;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_msb = out_data[OUT_WIDTH-1];

endmodule

// File: tb/tb_binary_stream_accumulator.sv
// Bench for binary_stream_accumulator: unsigned and signed instances share stimulus;
// results are checked against table constants and an arithmetic reference model.
module tb_binary_stream_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_bits = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_msb;
  logic [15:0] out_data;
  logic        in_ready_s, out_valid_s, out_msb_s;
  logic [15:0] out_data_s;

  int n_cmp = 0;
  int n_bad = 0;
  bit ready_rand = 1'b0;
  bit mon_en = 1'b1;
  bit hold_prev = 1'b0;
  logic [15:0] prev_data;
  logic [15:0] exp_u[$];
  logic [15:0] exp_s[$];

  typedef struct {
    logic [7:0][7:0] words;
    logic [15:0]     exp_u;
    logic [15:0]     exp_s;
  } vec_t;
  vec_t vecs[8];

  binary_stream_accumulator #(.NUM_LANES(8), .STREAM_BITS(8), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_msb(out_msb));

  binary_stream_accumulator #(.NUM_LANES(8), .STREAM_BITS(8), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_bits(in_bits), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_msb(out_msb_s));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_sum(input logic [7:0][7:0] w, input bit sgn);
    longint acc = 0;
    longint v;
    for (int l = 0; l < 8; l++) begin
      v = longint'(w[l]);
      if (sgn && v > 127) v = v - 256;
      acc = acc + v * (longint'(1) << l);
    end
    return acc[15:0];
  endfunction

  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (hold_prev) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", {16'b0, out_data}, {16'b0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_u.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0h required none", out_data);
        end else begin
          logic [15:0] eu, es;
          eu = exp_u.pop_front();
          es = exp_s.pop_front();
          check("result_u", {16'b0, out_data}, {16'b0, eu});
          check("result_s", {16'b0, out_data_s}, {16'b0, es});
          check("msb_u", {31'b0, out_msb}, {31'b0, eu[15]});
          check("msb_s", {31'b0, out_msb_s}, {31'b0, es[15]});
          check("valid_s", {31'b0, out_valid_s}, 32'd1);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [7:0] bits);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_bits  = bits;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: got in_ready=0 required 1 within 200 cycles");
    end
  endtask

  function automatic logic [7:0] beat_of(input logic [7:0][7:0] w, input int b);
    logic [7:0] bits;
    for (int l = 0; l < 8; l++) bits[l] = w[l][7-b];
    return bits;
  endfunction

  task automatic send_word(input logic [7:0][7:0] w, input int gap_pct, input bit do_exp,
                           input logic [15:0] eu, input logic [15:0] es);
    if (do_exp) begin
      exp_u.push_back(eu);
      exp_s.push_back(es);
    end
    for (int b = 0; b < 8; b++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        tick();
      end
      send_beat(beat_of(w, b));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0][7:0] w, wa, wb;
    vecs[0] = '{words: {8{8'h01}},              exp_u: 16'h00FF, exp_s: 16'h00FF};
    vecs[1] = '{words: 64'hFF00_0000_0000_0000, exp_u: 16'h7F80, exp_s: 16'hFF80};
    vecs[2] = '{words: 64'h0000_0000_0000_55AA, exp_u: 16'h0154, exp_s: 16'h0054};
    vecs[3] = '{words: 64'h0000_0000_0000_00FF, exp_u: 16'h00FF, exp_s: 16'hFFFF};
    vecs[4] = '{words: 64'h8000_0000_0000_0000, exp_u: 16'h4000, exp_s: 16'hC000};
    vecs[5] = '{words: {8{8'hFF}},              exp_u: 16'hFE01, exp_s: 16'hFF01};
    vecs[6] = '{words: {8{8'h80}},              exp_u: 16'h7F80, exp_s: 16'h8080};
    vecs[7] = '{words: 64'h0,                   exp_u: 16'h0000, exp_s: 16'h0000};

    #12;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", {16'b0, out_data}, 32'd0);
    check("rst_msb", {31'b0, out_msb}, 32'd0);
    reset = 1'b1;
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back word: result one cycle after the last beat, valid for one cycle.
    send_word(vecs[0].words, 0, 1'b1, vecs[0].exp_u, vecs[0].exp_s);
    check("t1_valid_after_last", {31'b0, out_valid}, 32'd1);
    check("t1_data", {16'b0, out_data}, 32'h00FF);
    tick();
    check("t1_valid_pulse", {31'b0, out_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i].words, 0, 1'b1, vecs[i].exp_u, vecs[i].exp_s);
    end
    repeat (3) tick();

    // Backpressure: last beat of B stalls while A is unconsumed.
    out_ready = 1'b0;
    wa = {8{8'h01}};
    wb = 64'h02;
    send_word(wa, 0, 1'b1, 16'h00FF, 16'h00FF);
    exp_u.push_back(16'h0002);
    exp_s.push_back(16'h0002);
    for (int b = 0; b < 7; b++) send_beat(beat_of(wb, b));
    in_valid = 1'b1;
    in_bits  = beat_of(wb, 7);
    @(negedge clk);
    check("t4_in_ready_low", {31'b0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("t4_in_ready_held", {31'b0, in_ready}, 32'd0);
    check("t4_a_pending", {16'b0, out_data}, 32'h00FF);
    tick();
    out_ready = 1'b1;
    #1;
    check("t4_in_ready_release", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("t4_b_loaded", {16'b0, out_data}, 32'h0002);
    check("t4_b_valid", {31'b0, out_valid}, 32'd1);
    repeat (3) tick();

    // Flush mid-word drops the partial word and the beat presented with it.
    for (int b = 0; b < 3; b++) send_beat(8'hFF);
    flush = 1'b1; in_valid = 1'b1; in_bits = 8'hFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    send_word(vecs[0].words, 0, 1'b1, 16'h00FF, 16'h00FF);
    repeat (2) tick();
    // Flush coinciding with the final beat produces no result.
    for (int b = 0; b < 7; b++) send_beat(8'h5A);
    flush = 1'b1; in_valid = 1'b1; in_bits = 8'h5A;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) tick();
    check("t5_no_result_on_last_flush", {31'b0, out_valid}, 32'd0);
    send_word(vecs[2].words, 0, 1'b1, vecs[2].exp_u, vecs[2].exp_s);
    repeat (3) tick();

    // Asynchronous reset with a pending result and a partial word.
    out_ready = 1'b0;
    send_word(vecs[5].words, 0, 1'b0, 16'h0, 16'h0);
    for (int b = 0; b < 5; b++) send_beat(8'hA5);
    in_valid = 1'b0;
    check("t6_pending", {31'b0, out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_data", {16'b0, out_data}, 32'd0);
    check("t6_rst_msb_s", {31'b0, out_msb_s}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    send_word(vecs[4].words, 0, 1'b1, vecs[4].exp_u, vecs[4].exp_s);
    repeat (3) tick();

    // Random words with gaps and random consumer backpressure.
    ready_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      w = {$urandom, $urandom};
      send_word(w, 25, 1'b1, ref_sum(w, 1'b0), ref_sum(w, 1'b1));
    end
    ready_rand = 1'b0;
    out_ready  = 1'b1;
    repeat (5) tick();
    check("queue_drained", exp_u.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
